core_bus_guard: RTL and testbench

Transaction guard between core_wrapper and bus on the native valid/ready memory interface. It registers each core request and forwards it downstream. If the downstream side does not answer within a bounded number of cycles, it returns a fixed error word to the core so the CPU cannot hang on a dead peripheral (e.g. PSRAM or an unresponsive APB slave). It records the failing address, counts errors, raises an interrupt line, and drains the orphaned downstream transaction before accepting new traffic.

---
 rtl/core_bus_guard.sv | 185 ++++++++++++++++++
 tb/tb_core_bus_guard.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_bus_guard.sv
// Transaction guard between the core and the downstream bus: forwards each request,
// returns ERR_RDATA if the bus stalls too long, records the error and drains the orphan.
module core_bus_guard #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        core_valid_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  input  logic [3:0]  core_wstrb_i,
  output logic [31:0] core_rdata_o,
  output logic        core_ready_o,
  output logic        bus_valid_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_wstrb_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ready_i,
  input  logic        tmo_en_i,
  input  logic        err_clr_i,
  output logic        err_irq_o,
  output logic [31:0] err_addr_o,
  output logic [7:0]  err_cnt_o,
  output logic        drain_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FWD   = 3'd1,
    RESP  = 3'd2,
    TOUT  = 3'd3,
    DRAIN = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_irq_q, err_irq_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        timeout_hit;

  assign timeout_hit = tmo_en_i && (wait_cnt_q == TMO_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A bus response always beats a timeout that expires in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (core_valid_i) state_d = FWD;
      end
      FWD: begin
        if (bus_ready_i) begin
          state_d = RESP;
        end else if (timeout_hit) begin
          state_d = TOUT;
        end
      end
      RESP: state_d = IDLE;
      TOUT: state_d = bus_ready_i ? IDLE : DRAIN;
      DRAIN: begin
        if (bus_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_valid_o  = 1'b0;
    core_ready_o = 1'b0;
    drain_o      = 1'b0;
    case (state_q)
      FWD: bus_valid_o = 1'b1;
      RESP: core_ready_o = 1'b1;
      TOUT: begin
        bus_valid_o  = 1'b1;
        core_ready_o = 1'b1;
      end
      DRAIN: begin
        bus_valid_o = 1'b1;
        drain_o     = 1'b1;
      end
      default: begin
        bus_valid_o  = 1'b0;
        core_ready_o = 1'b0;
        drain_o      = 1'b0;
      end
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    if ((state_q == IDLE) && core_valid_i) begin
      addr_d     = core_addr_i;
      wdata_d    = core_wdata_i;
      wstrb_d    = core_wstrb_i;
      wait_cnt_d = '0;
    end
    if (state_q == FWD) begin
      // Saturate rather than wrap so a long untimed stall cannot alias the limit.
      if (!(&wait_cnt_q)) wait_cnt_d = wait_cnt_q + CNT_W'(1);
      if (bus_ready_i) begin
        rdata_d = bus_rdata_i;
      end else if (timeout_hit) begin
        rdata_d = ERR_RDATA;
      end
    end
  end

  // A timeout in the same cycle as a clear wins, leaving a count of one.
  always_comb begin
    err_irq_d  = err_irq_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    if (err_clr_i) begin
      err_irq_d = 1'b0;
      err_cnt_d = '0;
    end
    if (state_q == TOUT) begin
      err_irq_d  = 1'b1;
      err_addr_d = addr_q;
      if (err_clr_i) begin
        err_cnt_d = 8'd1;
      end else if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wait_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      err_irq_q  <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      err_irq_q  <= err_irq_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign core_rdata_o = rdata_q;
  assign bus_addr_o   = addr_q;
  assign bus_wdata_o  = wdata_q;
  assign bus_wstrb_o  = wstrb_q;
  assign err_irq_o    = err_irq_q;
  assign err_addr_o   = err_addr_q;
  assign err_cnt_o    = err_cnt_q;

  ready_single_pulse: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    core_ready_o |=> !core_ready_o);
  drain_implies_valid: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    drain_o |-> bus_valid_o);

endmodule

// File: tb/tb_core_bus_guard.sv
// Randomized self-checking bench for core_bus_guard; expected results come from a
// transaction-level model (response delay vs. timeout window), not from the FSM.
module tb_core_bus_guard;

  localparam int T = 16;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        core_valid_i = 1'b0;
  logic [31:0] core_addr_i = '0;
  logic [31:0] core_wdata_i = '0;
  logic [3:0]  core_wstrb_i = '0;
  logic [31:0] core_rdata_o;
  logic        core_ready_o;
  logic        bus_valid_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_wstrb_o;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_ready_i = 1'b0;
  logic        tmo_en_i = 1'b1;
  logic        err_clr_i = 1'b0;
  logic        err_irq_o;
  logic [31:0] err_addr_o;
  logic [7:0]  err_cnt_o;
  logic        drain_o;

  int vectors = 0;
  int miscompares = 0;

  bit          exp_irq = 1'b0;
  int          exp_cnt = 0;
  logic [31:0] exp_eaddr = '0;

  core_bus_guard #(.TIMEOUT_CYCLES(T), .ERR_RDATA(ERR), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .core_valid_i(core_valid_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_wstrb_i(core_wstrb_i),
    .core_rdata_o(core_rdata_o), .core_ready_o(core_ready_o),
    .bus_valid_o(bus_valid_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
    .bus_rdata_i(bus_rdata_i), .bus_ready_i(bus_ready_i),
    .tmo_en_i(tmo_en_i), .err_clr_i(err_clr_i),
    .err_irq_o(err_irq_o), .err_addr_o(err_addr_o),
    .err_cnt_o(err_cnt_o), .drain_o(drain_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: a response d cycles after bus_valid rises completes normally iff d < T
  // (or timeouts are off); otherwise the core gets ERR after T cycles and the rest drains.
  task automatic model_txn(input logic [31:0] a, input logic [31:0] rd, input int d,
                           input bit tmo, input bit clr, output int e_lat,
                           output logic [31:0] e_rdata, output int e_drains);
    if (tmo && d >= T) begin
      e_lat = T;
      e_rdata = ERR;
      e_drains = d - T;
      exp_irq = 1'b1;
      exp_eaddr = a;
      exp_cnt = clr ? 1 : ((exp_cnt < 255) ? exp_cnt + 1 : 255);
    end else begin
      e_lat = d + 1;
      e_rdata = rd;
      e_drains = 0;
      if (clr) begin
        exp_irq = 1'b0;
        exp_cnt = 0;
      end
    end
  endtask

  // Acts as core and as a downstream slave answering d cycles after bus_valid rises.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input int d, input logic [31:0] rd, input bit tmo, input bit clr_at_resp,
                        input bit early_next, input logic [31:0] a2,
                        output int lat, output logic [31:0] got_rdata, output int vcnt,
                        output int pulses, output int drains, output logic [31:0] got_addr,
                        output logic [31:0] got_wdata, output logic [3:0] got_wstrb,
                        output bit addr_stable, output bit hung);
    int rise;
    bit seen;
    int since;
    rise = 0; seen = 1'b0; since = 0; lat = -1; got_rdata = '0; vcnt = 0; pulses = 0;
    drains = 0; got_addr = '0; got_wdata = '0; got_wstrb = '0; addr_stable = 1'b1; hung = 1'b1;
    core_valid_i = 1'b1; core_addr_i = a; core_wdata_i = wd; core_wstrb_i = ws; tmo_en_i = tmo;
    for (int c = 0; c < d + T + 40; c++) begin
      @(posedge clk_i); #1;
      bus_ready_i = 1'b0;
      err_clr_i = 1'b0;
      if (bus_valid_o) begin
        if (vcnt == 0) begin
          rise = c; got_addr = bus_addr_o; got_wdata = bus_wdata_o; got_wstrb = bus_wstrb_o;
        end
        if (bus_addr_o !== a) addr_stable = 1'b0;
        if (vcnt == d) bus_ready_i = 1'b1;
        vcnt++;
      end
      if (drain_o) drains++;
      if (core_ready_o) begin
        pulses++;
        if (!seen) begin
          lat = c - rise;
          got_rdata = core_rdata_o;
        end
        seen = 1'b1;
        core_valid_i = 1'b0;
        if (clr_at_resp) err_clr_i = 1'b1;
      end else if (seen) begin
        since++;
      end
      bus_rdata_i = bus_ready_i ? rd : $urandom();
      if (early_next && since >= 2) begin
        core_valid_i = 1'b1; core_addr_i = a2; core_wdata_i = '0; core_wstrb_i = '0;
      end
      if (seen && !bus_valid_o && !core_ready_o) begin
        hung = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    vectors++;
    if ({bus_valid_o, core_ready_o, drain_o, err_irq_o} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000", {bus_valid_o, core_ready_o, drain_o, err_irq_o});
    end
    vectors++;
    if ({core_rdata_o, bus_addr_o, bus_wdata_o, err_addr_o} !== 128'd0 || bus_wstrb_o !== 4'd0 || err_cnt_o !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: rdata %h addr %h cnt %0d expected zeros", core_rdata_o, bus_addr_o, err_cnt_o);
    end
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_read;
    int lat, vcnt, pulses, drains, e_lat, e_drains;
    logic [31:0] rdata, ga, gw, e_rdata;
    logic [3:0] gs;
    bit stable, hung;
    model_txn(32'h0300_0004, 32'h1234_5678, 2, 1'b1, 1'b0, e_lat, e_rdata, e_drains);
    do_txn(32'h0300_0004, 32'h0, 4'h0, 2, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h0,
           lat, rdata, vcnt, pulses, drains, ga, gw, gs, stable, hung);
    vectors++;
    if (hung || rdata !== e_rdata || lat !== e_lat) begin
      miscompares++;
      $display("[TB] FAIL read_resp: rdata %h lat %0d hung %0d expected %h lat %0d", rdata, lat, hung, e_rdata, e_lat);
    end
    vectors++;
    if (vcnt !== 3 || pulses !== 1) begin
      miscompares++;
      $display("[TB] FAIL read_handshake: valid cycles %0d pulses %0d expected 3 and 1", vcnt, pulses);
    end
    vectors++;
    if (err_irq_o !== 1'b0 || err_cnt_o !== 8'd0 || ga !== 32'h0300_0004 || gs !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL read_noerr: irq %b cnt %0d addr %h strb %h expected 0 0 03000004 0", err_irq_o, err_cnt_o, ga, gs);
    end
    repeat (3) @(posedge clk_i);
    #1;
    vectors++;
    if (core_rdata_o !== 32'h1234_5678) begin
      miscompares++;
      $display("[TB] FAIL read_hold: rdata %h expected 12345678", core_rdata_o);
    end
  endtask

  task automatic test_write;
    int lat, vcnt, pulses, drains, e_lat, e_drains;
    logic [31:0] rdata, ga, gw, e_rdata;
    logic [3:0] gs;
    bit stable, hung;
    model_txn(32'h0400_0010, 32'h0, 0, 1'b1, 1'b0, e_lat, e_rdata, e_drains);
    do_txn(32'h0400_0010, 32'hA5A5_0F0F, 4'b0011, 0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0,
           lat, rdata, vcnt, pulses, drains, ga, gw, gs, stable, hung);
    vectors++;
    if (ga !== 32'h0400_0010 || gw !== 32'hA5A5_0F0F || gs !== 4'b0011) begin
      miscompares++;
      $display("[TB] FAIL write_fwd: addr %h wdata %h strb %b expected 04000010 a5a50f0f 0011", ga, gw, gs);
    end
    vectors++;
    if (hung || lat !== e_lat || pulses !== 1) begin
      miscompares++;
      $display("[TB] FAIL write_latency: lat %0d pulses %0d expected %0d and 1", lat, pulses, e_lat);
    end
    vectors++;
    if (bus_addr_o !== 32'h0400_0010 || bus_wdata_o !== 32'hA5A5_0F0F || bus_wstrb_o !== 4'b0011) begin
      miscompares++;
      $display("[TB] FAIL write_hold: addr %h wdata %h expected held request", bus_addr_o, bus_wdata_o);
    end
  endtask

  task automatic test_timeout;
    int lat, vcnt, pulses, drains, e_lat, e_drains;
    logic [31:0] rdata, ga, gw, e_rdata;
    logic [3:0] gs;
    bit stable, hung;
    model_txn(32'h0500_0020, 32'h1111_2222, T + 5, 1'b1, 1'b0, e_lat, e_rdata, e_drains);
    do_txn(32'h0500_0020, 32'h0, 4'h0, T + 5, 32'h1111_2222, 1'b1, 1'b0, 1'b1, 32'h0600_0040,
           lat, rdata, vcnt, pulses, drains, ga, gw, gs, stable, hung);
    vectors++;
    if (hung || lat !== e_lat || rdata !== e_rdata) begin
      miscompares++;
      $display("[TB] FAIL tmo_resp: lat %0d rdata %h expected %0d %h", lat, rdata, e_lat, e_rdata);
    end
    vectors++;
    if (err_irq_o !== exp_irq || err_addr_o !== exp_eaddr || err_cnt_o !== 8'(exp_cnt)) begin
      miscompares++;
      $display("[TB] FAIL tmo_err: irq %b addr %h cnt %0d expected %b %h %0d", err_irq_o, err_addr_o, err_cnt_o, exp_irq, exp_eaddr, exp_cnt);
    end
    vectors++;
    if (drains !== e_drains || !stable || vcnt !== T + 6) begin
      miscompares++;
      $display("[TB] FAIL tmo_drain: drain cycles %0d stable %0d valid %0d expected %0d 1 %0d", drains, stable, vcnt, e_drains, T + 6);
    end
    model_txn(32'h0600_0040, 32'hCAFE_0001, 1, 1'b1, 1'b0, e_lat, e_rdata, e_drains);
    do_txn(32'h0600_0040, 32'h0, 4'h0, 1, 32'hCAFE_0001, 1'b1, 1'b0, 1'b0, 32'h0,
           lat, rdata, vcnt, pulses, drains, ga, gw, gs, stable, hung);
    vectors++;
    if (hung || ga !== 32'h0600_0040 || rdata !== e_rdata || lat !== e_lat) begin
      miscompares++;
      $display("[TB] FAIL tmo_next: addr %h rdata %h lat %0d expected 06000040 %h %0d", ga, rdata, lat, e_rdata, e_lat);
    end
  endtask

  task automatic test_races;
    int lat, vcnt, pulses, drains, e_lat, e_drains;
    logic [31:0] rdata, ga, gw, e_rdata;
    logic [3:0] gs;
    bit stable, hung;
    model_txn(32'h0700_0000, 32'h0, T, 1'b1, 1'b0, e_lat, e_rdata, e_drains);
    do_txn(32'h0700_0000, 32'h0, 4'h0, T, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0,
           lat, rdata, vcnt, pulses, drains, ga, gw, gs, stable, hung);
    vectors++;
    if (hung || drains !== 0 || err_cnt_o !== 8'(exp_cnt)) begin
      miscompares++;
      $display("[TB] FAIL race_ready_in_tout: drains %0d cnt %0d expected 0 %0d", drains, err_cnt_o, exp_cnt);
    end
    model_txn(32'h0700_0100, 32'h5A5A_A5A5, T - 1, 1'b1, 1'b0, e_lat, e_rdata, e_drains);
    do_txn(32'h0700_0100, 32'h0, 4'h0, T - 1, 32'h5A5A_A5A5, 1'b1, 1'b0, 1'b0, 32'h0,
           lat, rdata, vcnt, pulses, drains, ga, gw, gs, stable, hung);
    vectors++;
    if (hung || rdata !== e_rdata || lat !== e_lat || err_cnt_o !== 8'(exp_cnt)) begin
      miscompares++;
      $display("[TB] FAIL race_ready_wins: rdata %h lat %0d cnt %0d expected %h %0d %0d", rdata, lat, err_cnt_o, e_rdata, e_lat, exp_cnt);
    end
    model_txn(32'h0700_0200, 32'h0, T, 1'b1, 1'b1, e_lat, e_rdata, e_drains);
    do_txn(32'h0700_0200, 32'h0, 4'h0, T, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0,
           lat, rdata, vcnt, pulses, drains, ga, gw, gs, stable, hung);
    vectors++;
    if (hung || err_irq_o !== 1'b1 || err_cnt_o !== 8'd1 || err_addr_o !== 32'h0700_0200) begin
      miscompares++;
      $display("[TB] FAIL race_clr_tout: irq %b cnt %0d addr %h expected 1 1 07000200", err_irq_o, err_cnt_o, err_addr_o);
    end
    err_clr_i = 1'b1;
    @(posedge clk_i); #1;
    err_clr_i = 1'b0;
    exp_irq = 1'b0;
    exp_cnt = 0;
    vectors++;
    if (err_irq_o !== 1'b0 || err_cnt_o !== 8'd0 || err_addr_o !== exp_eaddr) begin
      miscompares++;
      $display("[TB] FAIL err_clear: irq %b cnt %0d addr %h expected 0 0 %h", err_irq_o, err_cnt_o, err_addr_o, exp_eaddr);
    end
  endtask

  task automatic test_random;
    int lat, vcnt, pulses, drains, e_lat, e_drains, d;
    logic [31:0] rdata, ga, gw, e_rdata, a, wd, rd;
    logic [3:0] gs, ws;
    bit stable, hung, tmo;
    for (int n = 0; n < 40; n++) begin
      a = $urandom(); wd = $urandom(); rd = $urandom(); ws = 4'($urandom_range(0, 15));
      d = $urandom_range(0, T + 6);
      tmo = ($urandom_range(0, 3) != 0);
      model_txn(a, rd, d, tmo, 1'b0, e_lat, e_rdata, e_drains);
      do_txn(a, wd, ws, d, rd, tmo, 1'b0, 1'b0, 32'h0,
             lat, rdata, vcnt, pulses, drains, ga, gw, gs, stable, hung);
      vectors++;
      if (hung || lat !== e_lat || rdata !== e_rdata || drains !== e_drains || vcnt !== d + 1 || pulses !== 1) begin
        miscompares++;
        $display("[TB] FAIL rand_txn%0d: lat %0d rdata %h drains %0d valid %0d expected %0d %h %0d %0d", n, lat, rdata, drains, vcnt, e_lat, e_rdata, e_drains, d + 1);
      end
      vectors++;
      if (ga !== a || gw !== wd || gs !== ws || err_cnt_o !== 8'(exp_cnt) || err_irq_o !== exp_irq || err_addr_o !== exp_eaddr) begin
        miscompares++;
        $display("[TB] FAIL rand_state%0d: addr %h cnt %0d irq %b eaddr %h expected %h %0d %b %h", n, ga, err_cnt_o, err_irq_o, err_addr_o, a, exp_cnt, exp_irq, exp_eaddr);
      end
    end
  endtask

  task automatic test_saturation;
    int lat, vcnt, pulses, drains, e_lat, e_drains, bad;
    logic [31:0] rdata, ga, gw, e_rdata, a;
    logic [3:0] gs;
    bit stable, hung;
    bad = 0;
    for (int n = 0; n < 300; n++) begin
      a = $urandom();
      model_txn(a, 32'h0, T, 1'b1, 1'b0, e_lat, e_rdata, e_drains);
      do_txn(a, 32'h0, 4'h0, T, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0,
             lat, rdata, vcnt, pulses, drains, ga, gw, gs, stable, hung);
      if (hung || rdata !== ERR) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("[TB] FAIL sat_responses: %0d bad timeout responses expected 0", bad);
    end
    vectors++;
    if (err_cnt_o !== 8'd255 || err_irq_o !== 1'b1 || err_addr_o !== exp_eaddr) begin
      miscompares++;
      $display("[TB] FAIL sat_count: cnt %0d irq %b addr %h expected 255 1 %h", err_cnt_o, err_irq_o, err_addr_o, exp_eaddr);
    end
    model_txn(32'h0800_0000, 32'h7777_8888, 5000, 1'b0, 1'b0, e_lat, e_rdata, e_drains);
    do_txn(32'h0800_0000, 32'h0, 4'h0, 5000, 32'h7777_8888, 1'b0, 1'b0, 1'b0, 32'h0,
           lat, rdata, vcnt, pulses, drains, ga, gw, gs, stable, hung);
    vectors++;
    if (hung || lat !== e_lat || rdata !== e_rdata || err_cnt_o !== 8'd255 || err_addr_o !== exp_eaddr) begin
      miscompares++;
      $display("[TB] FAIL tmo_disabled: lat %0d rdata %h cnt %0d expected %0d %h 255", lat, rdata, err_cnt_o, e_lat, e_rdata);
    end
  endtask

  task automatic test_reset_in_drain;
    int lat, vcnt, pulses, drains, e_lat, e_drains;
    logic [31:0] rdata, ga, gw, e_rdata;
    logic [3:0] gs;
    bit stable, hung, seen_drain;
    seen_drain = 1'b0;
    core_valid_i = 1'b1; core_addr_i = 32'h0900_0004; core_wstrb_i = 4'hF; core_wdata_i = 32'h1;
    tmo_en_i = 1'b1; bus_ready_i = 1'b0;
    for (int c = 0; c < T + 20; c++) begin
      @(posedge clk_i); #1;
      if (core_ready_o) core_valid_i = 1'b0;
      if (drain_o) begin
        seen_drain = 1'b1;
        break;
      end
    end
    core_valid_i = 1'b0;
    vectors++;
    if (!seen_drain) begin
      miscompares++;
      $display("[TB] FAIL rst_drain_entry: drain_o never rose expected 1");
    end
    repeat (3) @(posedge clk_i);
    #3;
    rst_n_i = 1'b0;
    #1;
    vectors++;
    if ({bus_valid_o, drain_o, core_ready_o, err_irq_o} !== 4'b0000 || err_cnt_o !== 8'd0 || err_addr_o !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL rst_async_ctrl: valid %b drain %b irq %b cnt %0d expected all 0", bus_valid_o, drain_o, err_irq_o, err_cnt_o);
    end
    vectors++;
    if (bus_addr_o !== 32'd0 || bus_wdata_o !== 32'd0 || bus_wstrb_o !== 4'd0 || core_rdata_o !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL rst_async_data: addr %h wdata %h rdata %h expected 0", bus_addr_o, bus_wdata_o, core_rdata_o);
    end
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    exp_irq = 1'b0; exp_cnt = 0; exp_eaddr = '0;
    @(posedge clk_i); #1;
    model_txn(32'h0300_0008, 32'h0BAD_F00D, 3, 1'b1, 1'b0, e_lat, e_rdata, e_drains);
    do_txn(32'h0300_0008, 32'h0, 4'h0, 3, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0, 32'h0,
           lat, rdata, vcnt, pulses, drains, ga, gw, gs, stable, hung);
    vectors++;
    if (hung || rdata !== e_rdata || lat !== e_lat || err_irq_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_recover: rdata %h lat %0d irq %b expected %h %0d 0", rdata, lat, err_irq_o, e_rdata, e_lat);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_races();
    test_random();
    test_saturation();
    test_reset_in_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
